// File: rtl/mux_nx1_wormhole.sv
// N:1 wormhole flit multiplexer with registered output, valid/ready backpressure and RR/select arbitration.
// Define MUX_STATS_EN to add the oflit_cnt/opkt_cnt transfer counters.
module mux_nx1_wormhole #(
  parameter int NPORT    = 4,
  parameter int DATAW    = 66,
  parameter int VCHW     = 2,
  parameter int ARB_MODE = 1
) (
  input  logic                     clk,
  input  logic                     rst_,
  input  logic [NPORT*DATAW-1:0]   idata,
  input  logic [NPORT-1:0]         ivalid,
  input  logic [NPORT*VCHW-1:0]    ivch,
  output logic [NPORT-1:0]         iready,
  input  logic [$clog2(NPORT)-1:0] sel,
  output logic [DATAW-1:0]         odata,
  output logic                     ovalid,
  output logic [VCHW-1:0]          ovch,
`ifdef MUX_STATS_EN
  output logic [31:0]              oflit_cnt,
  output logic [31:0]              opkt_cnt,
`endif
  input  logic                     oready
);

  localparam int PW = $clog2(NPORT);
  localparam logic [1:0] T_HEAD = 2'b01;
  localparam logic [1:0] T_TAIL = 2'b11;

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t           state;
  logic [PW-1:0]    rr_ptr;
  logic [PW-1:0]    grant;
  logic [PW-1:0]    winner;
  logic [PW-1:0]    acc_port;
  logic             found;
  logic             load;
  logic             accept;
  logic [1:0]       acc_type;
  logic [NPORT-1:0] cand;
  logic [DATAW-1:0] port_data [NPORT];
  logic [VCHW-1:0]  port_vch  [NPORT];

  // A port competes for the output only when it offers a HEAD flit.
  for (genvar p = 0; p < NPORT; p++) begin : g_port
    assign port_data[p] = idata[p*DATAW +: DATAW];
    assign port_vch[p]  = ivch[p*VCHW +: VCHW];
    assign cand[p]      = ivalid[p] &&
                          (idata[p*DATAW+DATAW-2 +: 2] == T_HEAD) &&
                          ((ARB_MODE != 0) || (sel == PW'(p)));
  end

  always_comb begin : arb
    int idx;
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int k = 0; k < NPORT; k++) begin
      idx = (int'(rr_ptr) + k) % NPORT;
      if (!found && cand[idx]) begin
        found  = 1'b1;
        winner = PW'(idx);
      end
    end
  end

  assign load = ~ovalid | oready;

  always_comb begin
    iready = '0;
    if (rst_) begin
      if (state == IDLE) begin
        if (found && load) iready[winner] = 1'b1;
      end else begin
        iready[grant] = load;
      end
    end
  end

  assign acc_port = (state == IDLE) ? winner : grant;
  assign accept   = |(ivalid & iready);
  assign acc_type = port_data[acc_port][DATAW-1 -: 2];

  // Output register and packet lock; the lock releases only once the TAIL has been taken.
  always_ff @(posedge clk) begin
    if (!rst_) begin
      state  <= IDLE;
      rr_ptr <= '0;
      grant  <= '0;
      odata  <= '0;
      ovch   <= '0;
      ovalid <= 1'b0;
    end else begin
      if (accept) begin
        odata  <= port_data[acc_port];
        ovch   <= port_vch[acc_port];
        ovalid <= 1'b1;
      end else if (oready) begin
        ovalid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (accept) begin
            state <= LOCKED;
            grant <= winner;
          end
        end
        LOCKED: begin
          if (accept && (acc_type == T_TAIL)) begin
            state  <= IDLE;
            rr_ptr <= (grant == PW'(NPORT-1)) ? '0 : grant + PW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MUX_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_) begin
      oflit_cnt <= '0;
      opkt_cnt  <= '0;
    end else if (ovalid && oready) begin
      oflit_cnt <= oflit_cnt + 32'd1;
      if (odata[DATAW-1 -: 2] == T_TAIL) opkt_cnt <= opkt_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mux_nx1_wormhole.sv
// Self-checking bench for mux_nx1_wormhole: directed vector table plus multi-cycle packet sequences.
// Counter checks are compiled in when MUX_STATS_EN is defined.
`timescale 1ns/1ps
module tb_mux_nx1_wormhole;

  localparam int NPORT = 4;
  localparam int DATAW = 66;
  localparam int VCHW  = 2;
  localparam logic [1:0] TN = 2'b00;
  localparam logic [1:0] TH = 2'b01;
  localparam logic [1:0] TD = 2'b10;
  localparam logic [1:0] TT = 2'b11;

  logic                   clk = 1'b0;
  logic                   rst_;
  logic [NPORT*DATAW-1:0] idata_a, idata_b;
  logic [NPORT-1:0]       ivalid_a, ivalid_b;
  logic [NPORT*VCHW-1:0]  ivch;
  logic [NPORT-1:0]       iready_a, iready_b;
  logic [1:0]             sel_a, sel_b;
  logic [DATAW-1:0]       odata_a, odata_b;
  logic                   ovalid_a, ovalid_b;
  logic [VCHW-1:0]        ovch_a, ovch_b;
  logic                   oready_a, oready_b;
`ifdef MUX_STATS_EN
  logic [31:0]            flit_a, pkt_a, flit_b, pkt_b;
`endif

  int checks = 0;
  int errors = 0;
  logic [67:0] exp_q[$];

  always #5 clk = ~clk;

  mux_nx1_wormhole #(.NPORT(NPORT), .DATAW(DATAW), .VCHW(VCHW), .ARB_MODE(1)) u_rr (
    .clk(clk), .rst_(rst_), .idata(idata_a), .ivalid(ivalid_a), .ivch(ivch),
    .iready(iready_a), .sel(sel_a), .odata(odata_a), .ovalid(ovalid_a), .ovch(ovch_a),
`ifdef MUX_STATS_EN
    .oflit_cnt(flit_a), .opkt_cnt(pkt_a),
`endif
    .oready(oready_a)
  );

  mux_nx1_wormhole #(.NPORT(NPORT), .DATAW(DATAW), .VCHW(VCHW), .ARB_MODE(0)) u_sel (
    .clk(clk), .rst_(rst_), .idata(idata_b), .ivalid(ivalid_b), .ivch(ivch),
    .iready(iready_b), .sel(sel_b), .odata(odata_b), .ovalid(ovalid_b), .ovch(ovch_b),
`ifdef MUX_STATS_EN
    .oflit_cnt(flit_b), .opkt_cnt(pkt_b),
`endif
    .oready(oready_b)
  );

  typedef struct {
    logic [3:0]  vld;
    logic [7:0]  typ;
    logic        ordy;
    logic [3:0]  rdy;
    logic        ov;
    logic [1:0]  ot;
    logic [63:0] opay;
    logic [1:0]  ovc;
  } vec_t;

  vec_t tbl [17];

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [1:0] vch_of(input int p);
    return 2'((p + 1) % 4);
  endfunction

  function automatic logic [65:0] src_flit(input int p, input int pos, input int plen);
    int f;
    logic [1:0] t;
    f = pos % plen;
    if (f == 0) t = TH;
    else if (f == plen - 1) t = TT;
    else t = TD;
    return {t, 64'(p * 4096 + pos)};
  endfunction

  task automatic set_port_a(input int p, input logic v, input logic [65:0] f);
    ivalid_a[p] = v;
    idata_a[p*DATAW +: DATAW] = f;
  endtask

  task automatic set_port_b(input int p, input logic v, input logic [65:0] f);
    ivalid_b[p] = v;
    idata_b[p*DATAW +: DATAW] = f;
  endtask

  task automatic applyStimulus(input vec_t v, input int i);
    for (int p = 0; p < NPORT; p++)
      set_port_a(p, v.vld[p], {v.typ[2*p +: 2], 64'(i * 16 + p)});
    oready_a = v.ordy;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_ = 1'b0;
    ivalid_a = '0; idata_a = '0; oready_a = 1'b1;
    ivalid_b = '0; idata_b = '0; oready_b = 1'b1; sel_b = '0;
    repeat (2) @(negedge clk);
    rst_ = 1'b1;
  endtask

  // Expected flit order when all ports in mask present packets at once: ascending round-robin.
  task automatic queue_order(input int plen, input int npk, input logic [3:0] mask);
    for (int pk = 0; pk < npk; pk++)
      for (int p = 0; p < NPORT; p++)
        if (mask[p])
          for (int f = 0; f < plen; f++)
            exp_q.push_back({vch_of(p), src_flit(p, pk * plen + f, plen)});
  endtask

  task automatic run_traffic(input string tag, input int plen, input int npk, input logic [3:0] mask,
                             input int stall_at, input int stall_len, output int first_out);
    int pos [4];
    int total, got, cyc;
    logic [65:0] held;
    logic [67:0] e;
    total = 0; got = 0; cyc = 0; first_out = -1; held = '0;
    for (int p = 0; p < NPORT; p++) begin
      pos[p] = 0;
      if (mask[p]) total += plen * npk;
    end
    while (got < total && cyc < 2000) begin
      @(negedge clk);
      oready_a = !(cyc >= stall_at && cyc < stall_at + stall_len);
      if (!oready_a) begin
        if (cyc == stall_at) held = odata_a;
        else checkOutput({tag, "_stall_data"}, 128'(odata_a), 128'(held));
        checkOutput({tag, "_stall_valid"}, 128'(ovalid_a), 128'(1));
      end else if (ovalid_a) begin
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else e = '1;
        checkOutput({tag, "_flit"}, 128'({ovch_a, odata_a}), 128'(e));
        if (first_out < 0) first_out = cyc;
        got++;
      end
      for (int p = 0; p < NPORT; p++) begin
        if (mask[p] && pos[p] < plen * npk) set_port_a(p, 1'b1, src_flit(p, pos[p], plen));
        else set_port_a(p, 1'b0, '0);
      end
      #1;
      if (!oready_a) checkOutput({tag, "_stall_iready"}, 128'(iready_a), 128'(0));
      checkOutput({tag, "_single_grant"}, 128'($countones(ivalid_a & iready_a) <= 1), 128'(1));
      for (int p = 0; p < NPORT; p++)
        if (ivalid_a[p] && iready_a[p]) pos[p]++;
      cyc++;
    end
    checkOutput({tag, "_flit_count"}, 128'(got), 128'(total));
    checkOutput({tag, "_queue_drained"}, 128'(exp_q.size()), 128'(0));
    exp_q.delete();
    @(negedge clk);
    ivalid_a = '0;
    oready_a = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int fo;
    ivch  = {2'd0, 2'd3, 2'd2, 2'd1};
    sel_a = '0;
    sel_b = '0;
    ivalid_b = '0; idata_b = '0; oready_b = 1'b1;

    tbl[0]  = '{4'b1010, 8'b01_00_01_00, 1'b1, 4'b0010, 1'b1, TH, 64'd1,   2'd2};
    tbl[1]  = '{4'b1010, 8'b01_00_10_00, 1'b1, 4'b0010, 1'b1, TD, 64'd17,  2'd2};
    tbl[2]  = '{4'b1010, 8'b01_00_11_00, 1'b1, 4'b0010, 1'b1, TT, 64'd33,  2'd2};
    tbl[3]  = '{4'b1011, 8'b01_00_01_01, 1'b1, 4'b1000, 1'b1, TH, 64'd51,  2'd0};
    tbl[4]  = '{4'b1011, 8'b01_00_01_01, 1'b1, 4'b1000, 1'b1, TH, 64'd67,  2'd0};
    tbl[5]  = '{4'b1001, 8'b00_00_00_01, 1'b1, 4'b1000, 1'b1, TN, 64'd83,  2'd0};
    tbl[6]  = '{4'b1001, 8'b11_00_00_01, 1'b0, 4'b0000, 1'b1, TN, 64'd83,  2'd0};
    tbl[7]  = '{4'b1001, 8'b11_00_00_01, 1'b1, 4'b1000, 1'b1, TT, 64'd115, 2'd0};
    tbl[8]  = '{4'b0001, 8'b00_00_00_01, 1'b0, 4'b0000, 1'b1, TT, 64'd115, 2'd0};
    tbl[9]  = '{4'b0001, 8'b00_00_00_01, 1'b1, 4'b0001, 1'b1, TH, 64'd144, 2'd1};
    tbl[10] = '{4'b0000, 8'b00_00_00_00, 1'b1, 4'b0001, 1'b0, TH, 64'd144, 2'd1};
    tbl[11] = '{4'b0001, 8'b00_00_00_11, 1'b1, 4'b0001, 1'b1, TT, 64'd176, 2'd1};
    tbl[12] = '{4'b0110, 8'b00_01_10_00, 1'b1, 4'b0100, 1'b1, TH, 64'd194, 2'd3};
    tbl[13] = '{4'b0110, 8'b00_11_10_00, 1'b0, 4'b0000, 1'b1, TH, 64'd194, 2'd3};
    tbl[14] = '{4'b0110, 8'b00_11_01_00, 1'b1, 4'b0100, 1'b1, TT, 64'd226, 2'd3};
    tbl[15] = '{4'b0110, 8'b00_01_01_00, 1'b1, 4'b0010, 1'b1, TH, 64'd241, 2'd2};
    tbl[16] = '{4'b0000, 8'b00_00_00_00, 1'b1, 4'b0010, 1'b0, TH, 64'd241, 2'd2};

    $display("[TB] reset with all ports requesting");
    rst_ = 1'b0;
    oready_a = 1'b1;
    for (int p = 0; p < NPORT; p++) set_port_a(p, 1'b1, {TH, 64'(p)});
    #1 checkOutput("T1_iready_in_reset", 128'(iready_a), 128'(0));
    repeat (2) @(posedge clk);
    #1;
    checkOutput("T1_ovalid", 128'(ovalid_a), 128'(0));
    checkOutput("T1_odata", 128'(odata_a), 128'(0));
    checkOutput("T1_ovch", 128'(ovch_a), 128'(0));
    checkOutput("T1_iready", 128'(iready_a), 128'(0));
    @(negedge clk);
    rst_ = 1'b1;
    ivalid_a = '0;
    @(posedge clk); #1;
    checkOutput("T1_no_flit_after_release", 128'(ovalid_a), 128'(0));

    $display("[TB] directed vector table");
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      applyStimulus(tbl[i], i);
      #1 checkOutput($sformatf("vec%0d_iready", i), 128'(iready_a), 128'(tbl[i].rdy));
      @(posedge clk); #1;
      checkOutput($sformatf("vec%0d_ovalid", i), 128'(ovalid_a), 128'(tbl[i].ov));
      checkOutput($sformatf("vec%0d_odata", i), 128'(odata_a), 128'({tbl[i].ot, tbl[i].opay}));
      checkOutput($sformatf("vec%0d_ovch", i), 128'(ovch_a), 128'(tbl[i].ovc));
    end

    $display("[TB] single 22-flit packet on port 1");
    do_reset();
    queue_order(22, 1, 4'b0010);
    run_traffic("T2", 22, 1, 4'b0010, 100000, 0, fo);
    checkOutput("T2_latency", 128'(fo), 128'(1));

    $display("[TB] round-robin across ports 0,2,3");
    do_reset();
    queue_order(3, 2, 4'b1101);
    run_traffic("T3", 3, 2, 4'b1101, 100000, 0, fo);

    $display("[TB] backpressure mid-packet");
    do_reset();
    queue_order(10, 2, 4'b0010);
    run_traffic("T4", 10, 2, 4'b0010, 4, 5, fo);

    $display("[TB] reset in the middle of a packet");
    do_reset();
    @(negedge clk);
    set_port_a(2, 1'b1, {TH, 64'h200});
    @(negedge clk);
    set_port_a(2, 1'b1, {TD, 64'h201});
    rst_ = 1'b0;
    @(negedge clk);
    rst_ = 1'b1;
    #1;
    checkOutput("RST_mid_ovalid", 128'(ovalid_a), 128'(0));
    checkOutput("RST_mid_iready", 128'(iready_a), 128'(0));
    @(posedge clk); #1;
    checkOutput("RST_mid_no_flit", 128'(ovalid_a), 128'(0));
    @(negedge clk);
    ivalid_a = '0;

    $display("[TB] select-mode arbitration");
    do_reset();
    @(negedge clk);
    sel_b = 2'd2;
    set_port_b(0, 1'b1, {TH, 64'h500});
    #1 checkOutput("T5_port0_stalled", 128'(iready_b), 128'(0));
    @(posedge clk); #1;
    checkOutput("T5_no_output", 128'(ovalid_b), 128'(0));
    @(negedge clk);
    set_port_b(2, 1'b1, {TH, 64'h520});
    #1 checkOutput("T5_grant_port2", 128'(iready_b), 128'(4'b0100));
    @(posedge clk); #1;
    checkOutput("T5_head2", 128'({ovalid_b, ovch_b, odata_b}), 128'({1'b1, 2'd3, TH, 64'h520}));
    @(negedge clk);
    sel_b = 2'd0;
    set_port_b(2, 1'b1, {TD, 64'h521});
    #1 checkOutput("T5_locked_after_sel", 128'(iready_b), 128'(4'b0100));
    @(posedge clk); #1;
    checkOutput("T5_data2", 128'(odata_b), 128'({TD, 64'h521}));
    @(negedge clk);
    set_port_b(2, 1'b1, {TT, 64'h522});
    #1 checkOutput("T5_tail_ready", 128'(iready_b), 128'(4'b0100));
    @(posedge clk); #1;
    checkOutput("T5_tail2", 128'(odata_b), 128'({TT, 64'h522}));
    @(negedge clk);
    set_port_b(2, 1'b0, '0);
    #1 checkOutput("T5_grant_port0", 128'(iready_b), 128'(4'b0001));
    @(posedge clk); #1;
    checkOutput("T5_head0", 128'({ovalid_b, ovch_b, odata_b}), 128'({1'b1, 2'd1, TH, 64'h500}));

`ifdef MUX_STATS_EN
    $display("[TB] flit and packet counters");
    do_reset();
    queue_order(22, 5, 4'b0011);
    run_traffic("T6", 22, 5, 4'b0011, 100000, 0, fo);
    checkOutput("T6_flit_cnt", 128'(flit_a), 128'(220));
    checkOutput("T6_pkt_cnt", 128'(pkt_a), 128'(10));
    do_reset();
    @(negedge clk);
    set_port_a(0, 1'b1, src_flit(0, 0, 22));
    @(negedge clk);
    set_port_a(0, 1'b1, src_flit(0, 1, 22));
    @(posedge clk); #1;
    checkOutput("T6_flit_cnt_run", 128'(flit_a), 128'(1));
    @(negedge clk);
    rst_ = 1'b0;
    @(posedge clk); #1;
    checkOutput("T6_flit_cnt_reset", 128'(flit_a), 128'(0));
    checkOutput("T6_pkt_cnt_reset", 128'(pkt_a), 128'(0));
    @(negedge clk);
    rst_ = 1'b1;
    ivalid_a = '0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
